// File: rtl/maze_pkg.sv
// maze_pkg
// Shared definitions for the maze path encoder: location field widths,
// the 2-bit direction codes, the controller state encoding and two small
// helpers that classify a step between two maze locations.
// No ports (package).

package maze_pkg;

   localparam int LOC_W = 8;
   localparam int ROW_W = 4;
   localparam int COL_W = 4;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      DRAIN  = 3'd2,
      FIN    = 3'd3,
      ERR    = 3'd4
   } state_t;

   // Priority direction of a step: any row change wins over a column
   // change, and "no rightward motion" falls through to LEFT.  For a true
   // single-cell step this gives exactly the right code.
   function automatic logic [1:0] step_dir(input logic [LOC_W-1:0] prev,
                                           input logic [LOC_W-1:0] cur);
      logic [1:0] d;
      if (cur[7:4] < prev[7:4])
         d = DIR_UP;
      else if (cur[7:4] > prev[7:4])
         d = DIR_DOWN;
      else if (cur[3:0] > prev[3:0])
         d = DIR_RIGHT;
      else
         d = DIR_LEFT;
      return d;
   endfunction

   // True only for a single orthogonal step.  The arithmetic is done one
   // bit wider so that 4-bit wraps such as col 15 -> 0 are not mistaken
   // for neighbours.
   function automatic logic is_adjacent(input logic [LOC_W-1:0] prev,
                                        input logic [LOC_W-1:0] cur);
      logic [ROW_W:0] pr;
      logic [ROW_W:0] cr;
      logic [COL_W:0] pc;
      logic [COL_W:0] cc;
      logic           same_row;
      logic           same_col;
      pr = {1'b0, prev[7:4]};
      cr = {1'b0, cur[7:4]};
      pc = {1'b0, prev[3:0]};
      cc = {1'b0, cur[3:0]};
      same_row = (pr == cr);
      same_col = (pc == cc);
      return (same_col && ((cr + 5'd1 == pr) || (pr + 5'd1 == cr))) ||
             (same_row && ((cc + 5'd1 == pc) || (pc + 5'd1 == cc)));
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo
// Show-ahead FIFO of 2-bit direction codes, DEPTH entries (power of two).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          synchronous flush; overrides push and pop
//   push, din    write request and data (caller must not push when full)
//   pop          read request (ignored when empty)
//   dout         head entry, forced to 00 while empty
//   full, empty  occupancy flags

module dir_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic [1:0] din,
   input  logic       pop,
   output logic [1:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [1:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full && !clr;
   assign pop_ok  = pop && !empty && !clr;

   // Head is masked while empty so a flushed FIFO shows 00, matching reset.
   assign dout = empty ? 2'b00 : mem[rd_ptr];

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/maze_path_encoder.sv
// maze_path_encoder
// Turns the rat-in-maze solver's stream of 8-bit locations ({row,col})
// into 2-bit direction codes, buffers them in a small FIFO and hands them
// to a downstream consumer over valid/ready.  Counts pushed directions and
// reports completion.
// Optional feature macro: PATH_CHK_EN -- when defined, every step must be a
// single orthogonal move; anything else parks the encoder in ERR with err=1.
// When undefined, every move after the first is priority-encoded and err=0.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   clr                  synchronous clear back to IDLE
//   move_vld/move_rdy    location handshake; move, move_last payload
//   dir_vld/dir/out_rdy  direction output handshake (show-ahead)
//   path_len             directions pushed on this path (saturating)
//   err                  sticky illegal-step flag
//   fin                  path complete and all directions delivered

module maze_path_encoder
   import maze_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             move_vld,
   output logic             move_rdy,
   input  logic [LOC_W-1:0] move,
   input  logic             move_last,
   output logic             dir_vld,
   output logic [1:0]       dir,
   input  logic             out_rdy,
   output logic [LEN_W-1:0] path_len,
   output logic             err,
   output logic             fin
);

   state_t           state;
   state_t           next_state;
   logic [LOC_W-1:0] prev_loc;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             load_prev;
   logic             step_ok;
   logic [1:0]       step_code;

   assign step_code = step_dir(prev_loc, move);

`ifdef PATH_CHK_EN
   assign step_ok = is_adjacent(prev_loc, move);
   assign err     = (state == ERR);
`else
   assign step_ok = 1'b1;
   assign err     = 1'b0;
`endif

   assign fin     = (state == FIN);
   assign dir_vld = !empty;
   assign pop     = dir_vld && out_rdy;

   // Controller: move_rdy depends only on state and FIFO fullness, never on
   // move_vld.  clr overrides everything, including a concurrent push.
   always_comb begin
      next_state = state;
      move_rdy   = 1'b0;
      push       = 1'b0;
      load_prev  = 1'b0;
      case (state)
         IDLE: begin
            move_rdy = 1'b1;
            if (move_vld) begin
               load_prev  = 1'b1;
               next_state = move_last ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            move_rdy = !full;
            if (move_vld && !full) begin
               if (step_ok) begin
                  push      = 1'b1;
                  load_prev = 1'b1;
                  if (move_last)
                     next_state = DRAIN;
               end else begin
                  next_state = ERR;
               end
            end
         end
         DRAIN: begin
            if (empty)
               next_state = FIN;
         end
         FIN: begin
            next_state = FIN;
         end
         ERR: begin
            move_rdy = 1'b1;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (clr) begin
         next_state = IDLE;
         push       = 1'b0;
         load_prev  = 1'b0;
      end
   end

   // State, last accepted location and the saturating path length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         prev_loc <= '0;
         path_len <= '0;
      end else if (clr) begin
         state    <= IDLE;
         prev_loc <= '0;
         path_len <= '0;
      end else begin
         state <= next_state;
         if (load_prev)
            prev_loc <= move;
         if (push && (path_len != '1))
            path_len <= path_len + LEN_W'(1);
      end
   end

   dir_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push),
      .din   (step_code),
      .pop   (pop),
      .dout  (dir),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: doc/maze_path_encoder.md
Name: maze_path_encoder

Overview:
- Downstream consumer of the rat-in-maze solver's move stream.
- Accepts the sequence of 8-bit maze locations ({row[7:4], col[3:0]}, 16x16 maze) emitted while the solver replays its path.
- Converts each consecutive location pair into a 2-bit direction code, buffers the codes in a small FIFO, and presents them on a valid/ready interface to a display/actuator stage.
- Tracks path length and flags illegal steps.

Parameters:
- DEPTH, 8, direction FIFO entries (power of two, >=2).
- LEN_W, 8, path_len counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: flush FIFO, zero counters, state to IDLE.
- move_vld  in  1  move/move_last valid.
- move_rdy  out  1  encoder accepts move this cycle.
- move  in  8  location: [7:4] row, [3:0] col.
- move_last  in  1  qualifies final location of the path.
- dir_vld  out  1  FIFO head valid.
- dir  out  2  FIFO head direction code.
- out_rdy  in  1  consumer accepts dir; pop when dir_vld && out_rdy.
- path_len  out  LEN_W  number of directions pushed this path.
- err  out  1  sticky illegal-step flag.
- fin  out  1  path complete and FIFO drained.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, FIFO empty, prev_loc=0, path_len=0, err=0, fin=0, dir_vld=0, dir=00. move_rdy reads 1 (IDLE). Reset mid-stream discards everything immediately.
- Handshake: a transfer occurs when move_vld && move_rdy. move_rdy is combinational from state/full only, never from move_vld.
- IDLE: move_rdy=1.
  - Accepted move is the start location: latched into prev_loc; no direction emitted.
  - move_last also set -> DRAIN; otherwise -> STREAM.
- STREAM: move_rdy = !full.
  - Each accepted move is compared against prev_loc:
    - row-1, same col -> UP 00.
    - col+1, same row -> RIGHT 01.
    - col-1, same row -> LEFT 10.
    - row+1, same col -> DOWN 11.
  - Legal step: push dir, prev_loc <= move, path_len+1 (saturates at all-ones, no wrap).
  - Illegal step (identical location, diagonal, distance>1, or 4-bit wrap such as col 15->0): nothing pushed -> ERR.
  - Legal step with move_last -> DRAIN.
- DRAIN: move_rdy=0. When the FIFO is empty -> FIN.
- FIN: fin=1, move_rdy=0. Hold until clr.
- ERR: err=1, move_rdy=1 (inputs discarded). FIFO still drains to the consumer. Hold until clr.
- clr: highest synchronous priority; same effect as reset except synchronous. Any concurrent push or pop is ignored.
- FIFO:
  - Show-ahead: dir = mem[rd_ptr], dir_vld = !empty.
  - Latency: an accepted move produces dir_vld the next cycle.
  - Simultaneous push and pop allowed when not full/empty; count unchanged.
  - When full, push is blocked by move_rdy=0 even if a pop happens the same cycle.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: PATH_CHK_EN.
- Defined: full adjacency check as above; illegal steps -> ERR.
- Undefined:
  - No ERR state; err is tied 0.
  - Every accepted move after the first is pushed using priority encoding: row decreased -> UP; row increased -> DOWN; else col increased -> RIGHT; else LEFT (includes identical location).

Decomposition:
- Shared package maze_pkg:
  - Direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11.
  - LOC_W=8, ROW/COL field widths of 4.
  - State encoding IDLE, STREAM, DRAIN, FIN, ERR.
- Sub-module dir_fifo: parameterised DEPTH x 2-bit show-ahead FIFO with full/empty. Controller, comparator and counters stay in the top.

Test Plan:
- Normal path: out_rdy=1, send 0x00, 0x01, 0x11, 0x12 (last) -> dir sequence 01, 11, 01; path_len=3; fin=1 one cycle after final pop; err=0.
- Backpressure: out_rdy=0, send 10 adjacent locations along row 0 (0x00..0x09, last on 0x09) -> 8 pushes, then move_rdy=0. Raise out_rdy -> 9 RIGHT codes delivered in order; path_len=9; fin=1.
- Illegal step (PATH_CHK_EN): 0x00 then 0x02 -> err=1 next cycle, no dir_vld, fin=0. clr -> IDLE, err=0, move_rdy=1.
- Wrap step (PATH_CHK_EN): 0x0F then 0x00 -> err=1. Without macro: same stimulus pushes LEFT 10, err=0.
- Single-location path: 0x35 with move_last -> DRAIN then FIN the next cycle; path_len=0; dir_vld never asserted.
- Reset mid-stream: assert rst low after 3 pushes with out_rdy=0 -> dir_vld, path_len, err, fin all 0 immediately, without waiting for a clock edge. Release -> new path encodes correctly.
